// File: rtl/dmem_if.sv
// Bundles the core data-memory bus and the secondary host command port
// so the responder and its drivers share one signal list.
interface dmem_if #(
  parameter int unsigned AW    = 7,
  parameter int unsigned CNT_W = 16
) ();
  logic             CEN;
  logic             WEN;
  logic             OEN;
  logic [AW-1:0]    A;
  logic [31:0]      Data2Mem;
  logic [31:0]      ReadDataMem;

  logic             host_req;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [31:0]      host_wdata;
  logic             host_gnt;
  logic             host_done;
  logic [31:0]      host_rdata;
  logic             host_busy;
  logic             host_starve;

  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output CEN, WEN, OEN, A, Data2Mem,
    output host_req, host_we, host_addr, host_wdata,
    input  ReadDataMem, host_gnt, host_done, host_rdata, host_busy, host_starve,
    input  rd_cnt, wr_cnt
  );

  modport slave (
    input  CEN, WEN, OEN, A, Data2Mem,
    input  host_req, host_we, host_addr, host_wdata,
    output ReadDataMem, host_gnt, host_done, host_rdata, host_busy, host_starve,
    output rd_cnt, wr_cnt
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory behind the single-cycle core: combinational core reads, edge writes,
// a host port that only touches memory in core-idle cycles, and saturating counters.
module dmem_responder #(
  parameter int unsigned WORDS        = 128,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    H_IDLE,
    H_PEND,
    H_DONE
  } h_state_e;

  function automatic logic [AW-1:0] wrap(input logic [31:0] addr);
    return AW'(addr % WORDS);
  endfunction

  logic [31:0]      mem [WORDS];
  h_state_e         state, state_nxt;
  logic [WW-1:0]    wait_cnt;
  logic             h_we;
  logic [AW-1:0]    h_addr;
  logic [31:0]      h_wdata;
  logic [31:0]      host_rdata;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  logic             core_rd, core_wr;
  logic [AW-1:0]    core_idx;
  logic             host_accept, host_fire;
  logic             host_gnt, host_done, host_busy, host_starve;

  // A write wins over a read when OEN and WEN are both low.
  assign core_wr  = !bus.CEN && !bus.WEN;
  assign core_rd  = !bus.CEN && !bus.OEN && bus.WEN;
  assign core_idx = wrap(32'(bus.A));

  assign bus.ReadDataMem = core_rd ? mem[core_idx] : '0;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt   = state;
    host_accept = 1'b0;
    host_fire   = 1'b0;
    host_gnt    = 1'b0;
    host_done   = 1'b0;
    host_busy   = 1'b0;
    host_starve = 1'b0;
    case (state)
      H_IDLE: begin
        host_gnt    = bus.host_req;
        host_accept = bus.host_req;
        if (bus.host_req) state_nxt = H_PEND;
      end
      H_PEND: begin
        host_busy   = 1'b1;
        host_starve = (wait_cnt == WW'(STARVE_LIMIT));
        // The core never stalls, so the host only gets cycles where CEN is high.
        if (bus.CEN) begin
          host_fire = 1'b1;
          state_nxt = H_DONE;
        end
      end
      H_DONE: begin
        host_done = 1'b1;
        state_nxt = H_IDLE;
      end
      default: state_nxt = H_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= H_IDLE;
      wait_cnt   <= '0;
      h_we       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (host_accept) begin
        h_we     <= bus.host_we;
        h_addr   <= wrap(32'(bus.host_addr));
        h_wdata  <= bus.host_wdata;
        wait_cnt <= '0;
      end else if (state == H_PEND && !bus.CEN && wait_cnt != WW'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (host_fire && !h_we) host_rdata <= mem[h_addr];
    end
  end

  // NOTE: the array is reset because a cleared memory is part of the visible reset state;
  // this forces it into flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (core_wr) begin
      mem[core_idx] <= bus.Data2Mem;
    end else if (host_fire && h_we) begin
      mem[h_addr] <= h_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (core_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (core_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign bus.host_gnt    = host_gnt;
  assign bus.host_done   = host_done;
  assign bus.host_busy   = host_busy;
  assign bus.host_starve = host_starve;
  assign bus.host_rdata  = host_rdata;
  assign bus.rd_cnt      = rd_cnt;
  assign bus.wr_cnt      = wr_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: core access, host port, starvation,
// ordering, reset and counter saturation (on a narrow-counter instance).
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dmem_if #(.AW(7), .CNT_W(16)) bus ();
  dmem_if #(.AW(7), .CNT_W(4))  bus4 ();

  dmem_responder #(.WORDS(128), .CNT_W(16), .STARVE_LIMIT(64)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dmem_responder #(.WORDS(128), .CNT_W(4), .STARVE_LIMIT(64)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    bus.CEN = 1'b1; bus.WEN = 1'b1; bus.OEN = 1'b1; bus.A = '0; bus.Data2Mem = '0;
  endtask

  task automatic core_read(input logic [6:0] a);
    bus.CEN = 1'b0; bus.WEN = 1'b1; bus.OEN = 1'b0; bus.A = a; bus.Data2Mem = '0;
  endtask

  task automatic core_write(input logic [6:0] a, input logic [31:0] d);
    bus.CEN = 1'b0; bus.WEN = 1'b0; bus.OEN = 1'b1; bus.A = a; bus.Data2Mem = d;
  endtask

  task automatic host_cmd(input logic req, input logic we, input logic [6:0] a, input logic [31:0] d);
    bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
  endtask

  task automatic do_reset();
    core_idle();
    host_cmd(1'b0, 1'b0, '0, '0);
    bus4.CEN = 1'b1; bus4.WEN = 1'b1; bus4.OEN = 1'b1; bus4.A = '0; bus4.Data2Mem = '0;
    bus4.host_req = 1'b0; bus4.host_we = 1'b0; bus4.host_addr = '0; bus4.host_wdata = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want %h", bus.ReadDataMem, 32'h0); end
    total++; if (bus.host_gnt !== 1'b0 || bus.host_done !== 1'b0 || bus.host_busy !== 1'b0 || bus.host_starve !== 1'b0) begin
      bad++; $display("FAIL reset_host_flags: gnt=%b done=%b busy=%b starve=%b want all 0", bus.host_gnt, bus.host_done, bus.host_busy, bus.host_starve);
    end
    total++; if (bus.host_rdata !== 32'h0) begin bad++; $display("FAIL reset_host_rdata: got %h want %h", bus.host_rdata, 32'h0); end
    total++; if (bus.rd_cnt !== 16'd0 || bus.wr_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: rd=%0d wr=%0d want 0 0", bus.rd_cnt, bus.wr_cnt); end
    core_read(7'd77);
    #1;
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL reset_mem77: got %h want %h", bus.ReadDataMem, 32'h0); end
    core_idle();
  endtask

  task automatic test_core_rw();
    do_reset();
    core_write(7'd5, 32'hDEADBEEF);
    #1;
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL rw_during_write: got %h want %h", bus.ReadDataMem, 32'h0); end
    tick();
    core_read(7'd5);
    #1;
    total++; if (bus.ReadDataMem !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_read5: got %h want %h", bus.ReadDataMem, 32'hDEADBEEF); end
    total++; if (bus.wr_cnt !== 16'd1) begin bad++; $display("FAIL rw_wr_cnt: got %0d want 1", bus.wr_cnt); end
    core_read(7'd6);
    #1;
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL rw_read6: got %h want %h", bus.ReadDataMem, 32'h0); end
    core_read(7'd5);
    tick();
    core_idle();
    #1;
    total++; if (bus.rd_cnt !== 16'd1) begin bad++; $display("FAIL rw_rd_cnt: got %0d want 1", bus.rd_cnt); end
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL rw_idle_rdata: got %h want %h", bus.ReadDataMem, 32'h0); end
  endtask

  task automatic test_host_read();
    do_reset();
    core_write(7'd9, 32'h12345678);
    tick();
    core_idle();
    host_cmd(1'b1, 1'b0, 7'd9, 32'h0);
    #1;
    total++; if (bus.host_gnt !== 1'b1) begin bad++; $display("FAIL hr_gnt_c0: got %b want 1", bus.host_gnt); end
    tick();
    host_cmd(1'b1, 1'b0, 7'd2, 32'h0);
    #1;
    total++; if (bus.host_gnt !== 1'b0 || bus.host_busy !== 1'b1 || bus.host_done !== 1'b0) begin
      bad++; $display("FAIL hr_c1: gnt=%b busy=%b done=%b want 0 1 0", bus.host_gnt, bus.host_busy, bus.host_done);
    end
    tick();
    host_cmd(1'b0, 1'b0, '0, '0);
    #1;
    total++; if (bus.host_done !== 1'b1 || bus.host_busy !== 1'b0) begin bad++; $display("FAIL hr_done_c2: done=%b busy=%b want 1 0", bus.host_done, bus.host_busy); end
    total++; if (bus.host_rdata !== 32'h12345678) begin bad++; $display("FAIL hr_rdata: got %h want %h", bus.host_rdata, 32'h12345678); end
    tick();
    #1;
    total++; if (bus.host_done !== 1'b0 || bus.host_rdata !== 32'h12345678) begin
      bad++; $display("FAIL hr_after: done=%b rdata=%h want 0 %h", bus.host_done, bus.host_rdata, 32'h12345678);
    end
  endtask

  task automatic test_host_starve();
    do_reset();
    host_cmd(1'b1, 1'b1, 7'd3, 32'hA5A5A5A5);
    #1;
    total++; if (bus.host_gnt !== 1'b1) begin bad++; $display("FAIL st_gnt: got %b want 1", bus.host_gnt); end
    tick();
    host_cmd(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 70; i++) begin
      core_read(7'd3);
      #1;
      total++; if (bus.host_busy !== 1'b1 || bus.host_starve !== (i >= 64) || bus.ReadDataMem !== 32'h0) begin
        bad++; $display("FAIL st_wait[%0d]: busy=%b starve=%b rdata=%h want 1 %b 0", i, bus.host_busy, bus.host_starve, bus.ReadDataMem, (i >= 64));
      end
      tick();
    end
    core_idle();
    #1;
    total++; if (bus.host_starve !== 1'b1 || bus.host_busy !== 1'b1) begin bad++; $display("FAIL st_access_cycle: starve=%b busy=%b want 1 1", bus.host_starve, bus.host_busy); end
    tick();
    total++; if (bus.host_done !== 1'b1 || bus.host_starve !== 1'b0 || bus.host_busy !== 1'b0) begin
      bad++; $display("FAIL st_done: done=%b starve=%b busy=%b want 1 0 0", bus.host_done, bus.host_starve, bus.host_busy);
    end
    total++; if (bus.rd_cnt !== 16'd70) begin bad++; $display("FAIL st_rd_cnt: got %0d want 70", bus.rd_cnt); end
    tick();
    core_read(7'd3);
    #1;
    total++; if (bus.ReadDataMem !== 32'hA5A5A5A5) begin bad++; $display("FAIL st_mem3: got %h want %h", bus.ReadDataMem, 32'hA5A5A5A5); end
    core_idle();
  endtask

  task automatic test_ordering();
    do_reset();
    core_write(7'd7, 32'h11110000);
    tick();
    core_idle();
    host_cmd(1'b1, 1'b0, 7'd7, 32'h0);
    tick();
    host_cmd(1'b0, 1'b0, '0, '0);
    core_write(7'd7, 32'h0000BEEF);
    #1;
    total++; if (bus.host_busy !== 1'b1) begin bad++; $display("FAIL ord_busy: got %b want 1", bus.host_busy); end
    tick();
    core_idle();
    tick();
    total++; if (bus.host_done !== 1'b1 || bus.host_rdata !== 32'h0000BEEF) begin
      bad++; $display("FAIL ord_rdata: done=%b rdata=%h want 1 %h", bus.host_done, bus.host_rdata, 32'h0000BEEF);
    end
  endtask

  task automatic test_both_low();
    do_reset();
    bus.CEN = 1'b0; bus.WEN = 1'b0; bus.OEN = 1'b0; bus.A = 7'd2; bus.Data2Mem = 32'h1;
    #1;
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL bl_rdata: got %h want %h", bus.ReadDataMem, 32'h0); end
    tick();
    core_read(7'd2);
    #1;
    total++; if (bus.ReadDataMem !== 32'h1) begin bad++; $display("FAIL bl_mem2: got %h want %h", bus.ReadDataMem, 32'h1); end
    total++; if (bus.wr_cnt !== 16'd1 || bus.rd_cnt !== 16'd0) begin bad++; $display("FAIL bl_cnt: wr=%0d rd=%0d want 1 0", bus.wr_cnt, bus.rd_cnt); end
    core_idle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    core_write(7'd5, 32'hCAFEF00D);
    tick();
    core_idle();
    host_cmd(1'b1, 1'b0, 7'd5, 32'h0);
    tick();
    host_cmd(1'b0, 1'b0, '0, '0);
    tick();
    total++; if (bus.host_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mr_pre_rdata: got %h want %h", bus.host_rdata, 32'hCAFEF00D); end
    tick();
    host_cmd(1'b1, 1'b1, 7'd4, 32'h44444444);
    tick();
    host_cmd(1'b0, 1'b0, '0, '0);
    core_read(7'd5);
    #1;
    total++; if (bus.ReadDataMem !== 32'hCAFEF00D || bus.host_busy !== 1'b1) begin
      bad++; $display("FAIL mr_pre: rdata=%h busy=%b want %h 1", bus.ReadDataMem, bus.host_busy, 32'hCAFEF00D);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.ReadDataMem !== 32'h0 || bus.host_rdata !== 32'h0) begin
      bad++; $display("FAIL mr_async_data: rdata=%h host_rdata=%h want 0 0", bus.ReadDataMem, bus.host_rdata);
    end
    total++; if (bus.host_busy !== 1'b0 || bus.host_gnt !== 1'b0 || bus.host_done !== 1'b0 || bus.host_starve !== 1'b0) begin
      bad++; $display("FAIL mr_async_flags: busy=%b gnt=%b done=%b starve=%b want 0", bus.host_busy, bus.host_gnt, bus.host_done, bus.host_starve);
    end
    total++; if (bus.rd_cnt !== 16'd0 || bus.wr_cnt !== 16'd0) begin bad++; $display("FAIL mr_async_cnt: rd=%0d wr=%0d want 0 0", bus.rd_cnt, bus.wr_cnt); end
    tick();
    rst_n = 1'b1;
    core_idle();
    tick();
    total++; if (bus.host_busy !== 1'b0 || bus.host_done !== 1'b0) begin bad++; $display("FAIL mr_dropped: busy=%b done=%b want 0 0", bus.host_busy, bus.host_done); end
    core_read(7'd4);
    #1;
    total++; if (bus.ReadDataMem !== 32'h0) begin bad++; $display("FAIL mr_mem4: got %h want %h", bus.ReadDataMem, 32'h0); end
    core_idle();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    bus4.CEN = 1'b0; bus4.WEN = 1'b1; bus4.OEN = 1'b0; bus4.A = 7'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      total++; if (bus4.rd_cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL sat_rd[%0d]: got %0d want %0d", i, bus4.rd_cnt, exp_cnt); end
    end
    total++; if (bus4.wr_cnt !== 4'd0) begin bad++; $display("FAIL sat_wr: got %0d want 0", bus4.wr_cnt); end
    bus4.CEN = 1'b1; bus4.OEN = 1'b1;
    tick();
    total++; if (bus4.rd_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", bus4.rd_cnt); end
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    total = 0;
    bad   = 0;
    do_reset();
    test_reset();
    test_core_rw();
    test_host_read();
    test_host_starve();
    test_ordering();
    test_both_low();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
